// File: rtl/shift_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_pipe
//  Description : Two-stage pipelined barrel shifter/rotator (SLL, SRA, ROR,
//                ROL) with valid/ready handshakes and output backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_unit_pipe #(
  parameter int WIDTH = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam int c_LO = (SHAMT_W + 1) / 2;
  localparam int c_HI = SHAMT_W - c_LO;

  localparam logic [1:0] c_SLL = 2'b00;
  localparam logic [1:0] c_SRA = 2'b01;
  localparam logic [1:0] c_ROR = 2'b10;
  localparam logic [1:0] c_ROL = 2'b11;

  // One log-stage move by n positions; rotates are always rightward here.
  function automatic logic [WIDTH-1:0] f_move(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int unsigned      n
  );
    logic [2*WIDTH-1:0] w_ext;
    unique case (mode)
      c_SLL:   w_ext = {{WIDTH{1'b0}}, d << n};
      c_SRA:   w_ext = {{WIDTH{sign}}, d} >> n;
      default: w_ext = {d, d} >> n;
    endcase
    return w_ext[WIDTH-1:0];
  endfunction

  logic [SHAMT_W-1:0] w_amt;
  logic [1:0]         w_mode;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic               w_s2_adv;
  logic               w_s1_adv;

  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_data;
  logic [c_HI-1:0]    r_s1_amt;
  logic [1:0]         r_s1_mode;
  logic               r_s1_sign;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_zero;

  // ROL by n is folded into ROR by (WIDTH-n) mod WIDTH before the first stage.
  assign w_amt  = (in_mode == c_ROL) ? (SHAMT_W'(0) - in_shamt) : in_shamt;
  assign w_mode = (in_mode == c_ROL) ? c_ROR : in_mode;

  always_comb begin
    w_lo = in_data;
    for (int k = 0; k < c_LO; k++) begin
      if (w_amt[k]) begin
        w_lo = f_move(w_lo, w_mode, in_data[WIDTH-1], 1 << k);
      end
    end
  end

  always_comb begin
    w_hi = r_s1_data;
    for (int k = 0; k < c_HI; k++) begin
      if (r_s1_amt[k]) begin
        w_hi = f_move(w_hi, r_s1_mode, r_s1_sign, 1 << (k + c_LO));
      end
    end
  end

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = w_s2_adv;
  assign in_ready = !r_s1_valid || w_s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_amt    <= '0;
      r_s1_mode   <= c_SLL;
      r_s1_sign   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_hi;
          r_out_zero <= (w_hi == '0);
        end
      end
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_data <= w_lo;
          r_s1_amt  <= w_amt[SHAMT_W-1:c_LO];
          r_s1_mode <= w_mode;
          r_s1_sign <= in_data[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit_pipe
//  Description : Scoreboard bench for shift_unit_pipe at WIDTH 16, 8 and 32.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shift_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        in_ready, out_valid, out_zero;
  logic [15:0] out_data;

  logic        in_valid_8, out_ready_8;
  logic [7:0]  in_data_8;
  logic [2:0]  in_shamt_8;
  logic [1:0]  in_mode_8;
  logic        in_ready_8, out_valid_8, out_zero_8;
  logic [7:0]  out_data_8;

  logic        in_valid_32, out_ready_32;
  logic [31:0] in_data_32;
  logic [4:0]  in_shamt_32;
  logic [1:0]  in_mode_32;
  logic        in_ready_32, out_valid_32, out_zero_32;
  logic [31:0] out_data_32;

  shift_unit_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero));

  shift_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_data(in_data_8), .in_shamt(in_shamt_8), .in_mode(in_mode_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .out_data(out_data_8), .out_zero(out_zero_8));

  shift_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .in_data(in_data_32), .in_shamt(in_shamt_32), .in_mode(in_mode_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32), .out_data(out_data_32), .out_zero(out_zero_32));

  typedef struct {
    logic [31:0] data;
    logic        zero;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q16[$], q8[$], q32[$];
  exp_t e16, e8, e32;
  int   n_chk = 0, n_pass = 0, cyc = 0, acc = 0;
  bit   lat_on = 1'b0, rnd_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    $display("FAIL %s", name);
  endtask

  // Bit-by-bit reference, independent of any log-stage decomposition.
  function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                        input logic [1:0] m, input int w);
    logic [31:0] r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00:   r[i] = (i - s >= 0) ? d[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < w) ? d[i+s] : d[w-1];
        2'b10:   r[i] = d[(i+s)%w];
        default: r[i] = d[(i-s+w)%w];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) flag_fail("w16 spurious output");
      else begin
        e16 = q16.pop_front();
        check("w16 data", 32'(out_data), e16.data);
        check("w16 zero", 32'(out_zero), 32'(e16.zero));
        if (e16.lat) check("w16 latency", 32'(cyc - e16.cyc), 32'd2);
      end
    end
    if (rst_n && out_valid_8 && out_ready_8) begin
      if (q8.size() == 0) flag_fail("w8 spurious output");
      else begin
        e8 = q8.pop_front();
        check("w8 data", 32'(out_data_8), e8.data);
        check("w8 zero", 32'(out_zero_8), 32'(e8.zero));
      end
    end
    if (rst_n && out_valid_32 && out_ready_32) begin
      if (q32.size() == 0) flag_fail("w32 spurious output");
      else begin
        e32 = q32.pop_front();
        check("w32 data", out_data_32, e32.data);
        check("w32 zero", 32'(out_zero_32), 32'(e32.zero));
      end
    end
  end

  task automatic send(input int w, input logic [31:0] d, input int s,
                      input logic [1:0] m, input logic [31:0] e);
    int   t = 0;
    logic rdy;
    exp_t x;
    x = '{data: e, zero: (e == 32'd0), cyc: 0, lat: lat_on};
    case (w)
      8:       begin in_valid_8  = 1'b1; in_data_8  = d[7:0];  in_shamt_8  = 3'(s); in_mode_8  = m; end
      32:      begin in_valid_32 = 1'b1; in_data_32 = d;       in_shamt_32 = 5'(s); in_mode_32 = m; end
      default: begin in_valid    = 1'b1; in_data    = d[15:0]; in_shamt    = 4'(s); in_mode    = m; end
    endcase
    forever begin
      @(negedge clk);
      rdy = (w == 8) ? in_ready_8 : (w == 32) ? in_ready_32 : in_ready;
      if (rdy) begin
        x.cyc = cyc;
        if (w == 8) q8.push_back(x);
        else if (w == 32) q32.push_back(x);
        else q16.push_back(x);
        acc++;
        break;
      end
      t++;
      if (t > 200) begin
        flag_fail("input handshake timeout");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_8 = 1'b0; in_valid_32 = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  logic [15:0] bp_exp [5] = '{16'h0006, 16'h000C, 16'h0018, 16'h0030, 16'h0060};

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; in_shamt = 0; in_mode = 0; out_ready = 1;
    in_valid_8 = 0; in_data_8 = 0; in_shamt_8 = 0; in_mode_8 = 0; out_ready_8 = 1;
    in_valid_32 = 0; in_data_32 = 0; in_shamt_32 = 0; in_mode_32 = 0; out_ready_32 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_zero", 32'(out_zero), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset w8 in_ready", 32'(in_ready_8), 32'd1);
    check("reset w32 out_valid", 32'(out_valid_32), 32'd0);
    @(posedge clk); #1;

    lat_on = 1'b1;
    send(16, 32'h1234, 4,  2'b10, 32'h4123);
    send(16, 32'h8001, 1,  2'b11, 32'h0003);
    send(16, 32'h0001, 15, 2'b00, 32'h8000);
    send(16, 32'h8000, 15, 2'b01, 32'hFFFF);
    send(16, 32'h7FFF, 15, 2'b01, 32'h0000);
    drain();

    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 16; s++)
        send(16, 32'hA5C3, s, 2'(m), (s == 0) ? 32'hA5C3 : model(32'hA5C3, s, 2'(m), 16));
    drain();

    lat_on = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(16, 32'h0003, i + 1, 2'b00, 32'(bp_exp[i]));
      end
      begin
        for (int t = 0; t < 50 && acc < 2; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("bp accepted beats", 32'(acc), 32'd2);
        check("bp in_ready low", 32'(in_ready), 32'd0);
        check("bp out_valid held", 32'(out_valid), 32'd1);
        check("bp out_data stable", 32'(out_data), 32'(bp_exp[0]));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp queue drained", 32'(q16.size()), 32'd0);

    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        logic [15:0] d;
        int          s;
        logic [1:0]  m;
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
          d = 16'($urandom);
          s = $urandom_range(0, 15);
          m = 2'($urandom_range(0, 3));
          send(16, 32'(d), s, m, model(32'(d), s, m, 16));
        end
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain();
    check("random queue drained", 32'(q16.size()), 32'd0);

    out_ready = 1'b0;
    send(16, 32'h1111, 3, 2'b10, 32'h2222);
    send(16, 32'h0F0F, 2, 2'b00, 32'h3C3C);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q16.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data", 32'(out_data), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    lat_on = 1'b1;
    send(16, 32'h00F0, 8, 2'b10, 32'hF000);
    drain();
    check("post reset queue drained", 32'(q16.size()), 32'd0);

    lat_on = 1'b0;
    send(8, 32'h81, 1, 2'b10, 32'hC0);
    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 8; s++)
        send(8, 32'hA5, s, 2'(m), model(32'hA5, s, 2'(m), 8));
    send(32, 32'h8000_0000, 31, 2'b01, 32'hFFFF_FFFF);
    for (int m = 0; m < 4; m++)
      for (int s = 0; s < 32; s++)
        send(32, 32'hA5C3_96E1, s, 2'(m), model(32'hA5C3_96E1, s, 2'(m), 32));
    drain();
    check("w8 queue drained", 32'(q8.size()), 32'd0);
    check("w32 queue drained", 32'(q32.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shift/rotate unit for the ALU.
- Supports left shift, arithmetic right shift, rotate right and rotate left.
- Operand width is configurable; the datapath has two register stages.
- Operands enter and results leave through valid/ready handshakes, and the output side supports backpressure.

Parameters:
WIDTH, 16, data width in bits; power of two, >= 4
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept operand this cycle
in_data  input  WIDTH  value to shift
in_shamt  input  SHAMT_W  shift/rotate amount, 0..WIDTH-1
in_mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 ROL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted/rotated result
out_zero  output  1  out_data == 0

Behaviour:
- Reset:
  - Sampled on the rising clk edge while rst_n == 0.
  - Clears s1_valid, s2_valid and out_valid.
  - Clears out_data and out_zero to 0.
  - in_ready is 1 in the first cycle after reset deassertion.
- Structure:
  - Stage S1 register holds the operand after the low ceil(SHAMT_W/2) log-stages, plus the remaining shamt bits and mode.
  - Stage S2 is the output register (out_data/out_valid) holding the completed result.
  - Combinational logic between S1 and S2 applies the remaining log-stages.
  - Each log-stage k conditionally moves by 2^k, selected by shamt[k].
- Log-stage operations:
  - SLL fills with 0.
  - SRA fills with in_data[WIDTH-1]; the sign is carried with the S1 data.
  - ROR/ROL wrap bits around.
  - ROL by n is equal to ROR by (WIDTH-n) mod WIDTH. Implement it directly or by reversal; only the result is specified.
- Latency and throughput:
  - Latency is 2 cycles from input handshake (in_valid && in_ready at edge t) to out_valid at t+2 with no backpressure.
  - Throughput is 1 result per cycle.
- Stall rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid || s1_adv. in_ready is combinational and depends on out_ready, with no dependence on in_valid.
  - When s2_adv: out_valid <= s1_valid. If s1_valid, out_data and out_zero are loaded.
  - When in_ready: s1_valid <= in_valid, and S1 loads when in_valid.
  - While stalled, S1 and S2 contents are held stable, and out_data does not change while out_valid && !out_ready.
- Simultaneous events:
  - An input handshake and an output handshake in the same cycle with a full pipe advance both stages; no bubble and no loss.
  - With out_ready held at 0, the unit absorbs at most 2 beats, then drops in_ready.
- Shift amount:
  - shamt == 0 returns in_data unchanged for every mode.
  - shamt == WIDTH-1 is the maximum.
  - Amounts >= WIDTH are not representable.
- Mode 01 (SRA): a negative operand shifted by WIDTH-1 yields all ones; a positive operand yields 0.
- out_zero is registered together with out_data and is valid whenever out_valid is 1.
- Reset mid-operation: in-flight beats are discarded with no partial output, and out_valid is 0 the cycle after reset.
- Inputs sampled when in_valid == 0 are don't-care and are never propagated.

Test Plan:
- Basic modes, WIDTH=16, out_ready=1:
  - ROR 0x1234 by 4 -> 0x4123
  - ROL 0x8001 by 1 -> 0x0003
  - SLL 0x0001 by 15 -> 0x8000
  - SRA 0x8000 by 15 -> 0xFFFF
  - SRA 0x7FFF by 15 -> 0x0000 with out_zero=1
  - Each result has out_valid exactly 2 cycles after its input handshake.
- Exhaustive sweep: all 4 modes × shamt 0..15 on 0xA5C3, back-to-back, with out_ready=1.
  - One result per cycle, in order.
  - Every result matches a reference model.
  - shamt=0 returns 0xA5C3.
- Backpressure:
  - Stream 5 beats while holding out_ready=0.
  - in_ready drops after 2 accepted beats.
  - out_data stays stable.
  - Release out_ready: all 5 results are delivered in order with no duplicates.
- Random out_ready toggling (50%) with random in_valid over 1000 beats: scoreboard shows no loss, no reorder and no duplication.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 beats in flight.
  - Next cycle: out_valid=0, out_data=0, in_ready=1.
  - The in-flight results never appear.
  - A new beat (ROR 0x00F0 by 8 -> 0xF000) completes normally.
- Parametrisation: rerun the sweep at WIDTH=8 and WIDTH=32.
  - WIDTH=8: ROR 0x81 by 1 -> 0xC0.
  - WIDTH=32: SRA 0x80000000 by 31 -> 0xFFFFFFFF.
